// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer. It keeps at most one memory
// request outstanding and presents each fetched instruction to the IF/ID
// register.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   redirect_valid/_pc     branch/jump/trap redirect; highest priority
//   id_stall, buf_full     downstream back-pressure sources
//   imem_req/_addr/_gnt    fetch request handshake
//   imem_rvalid/_rdata     fetch response
//   if_valid/_pc/_pc4/_inst  fetched instruction for IF/ID
//   ifid_stall, ifid_flush   IF/ID hold / invalidate
//   fetch_stall_cnt        (FETCH_PERF_CNT_EN only) saturating count of cycles
//                          spent in REQ without gnt, WAIT, or HOLD
//
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  id_stall,
  input  logic                  buf_full,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc4,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  ifid_stall,
  output logic                  ifid_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  redir;
  logic                  fwd_rdata;

  assign ifid_stall = id_stall | buf_full;
  assign pc_inc     = pc_q + ADDR_WIDTH'(4);
  // Reset overrides a concurrent redirect so ifid_flush stays low in reset.
  assign redir      = redirect_valid & ~reset;
  assign imem_addr  = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    ifid_flush = 1'b0;
    fwd_rdata  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d    = imem_rdata;
          fwd_rdata = 1'b1;
          if (!ifid_stall) begin
            if_valid = 1'b1;
            pc_d     = pc_inc;
            state_d  = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if (!ifid_stall) begin
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over everything above. An accepted-but-unanswered request
    // must have its response drained before the new target is fetched.
    if (redir) begin
      ifid_flush = 1'b1;
      if_valid   = 1'b0;
      fwd_rdata  = 1'b0;
      inst_d     = inst_q;
      pc_d       = redirect_pc;
      case (state_q)
        S_REQ:   state_d = imem_gnt    ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        // A response landing together with the redirect ends the drain;
        // staying would wait forever for a second response.
        S_DRAIN: state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Response is forwarded in its arrival cycle, then held from inst_q.
  assign if_inst = fwd_rdata ? imem_rdata : inst_q;
  assign if_pc   = if_valid ? pc_q   : '0;
  assign if_pc4  = if_valid ? pc_inc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        stall_cyc;

  assign stall_cyc = (state_q == S_REQ && !imem_gnt) ||
                     (state_q == S_WAIT) || (state_q == S_HOLD);

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cyc && cnt_q != '1) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A second instance with a wrapping
// RESET_PC shares the stimulus to exercise PC wrap-around.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_stall, buf_full;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, if_valid, ifid_stall, ifid_flush;
  logic [63:0] imem_addr, if_pc, if_pc4;
  logic [31:0] if_inst;

  logic        w_req, w_valid, w_stall, w_flush;
  logic [63:0] w_addr, w_pc, w_pc4;
  logic [31:0] w_inst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt, w_cnt, cnt_snap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .buf_full(buf_full), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_stall_cnt(cnt)
`endif
  );

  fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .buf_full(buf_full), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(w_valid), .if_pc(w_pc), .if_pc4(w_pc4), .if_inst(w_inst),
    .ifid_stall(w_stall), .ifid_flush(w_flush)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_stall_cnt(w_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    id_stall = 1'b0; buf_full = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step(); step();

    // reset state
    chk("rst_req",   imem_req,   1'b0);
    chk("rst_addr",  imem_addr,  64'h0);
    chk("rst_waddr", w_addr,     64'hFFFF_FFFF_FFFF_FFFC);
    chk("rst_valid", if_valid,   1'b0);
    chk("rst_pc",    if_pc,      64'h0);
    chk("rst_pc4",   if_pc4,     64'h0);
    chk("rst_inst",  if_inst,    32'h0);
    redirect_valid = 1'b1; #1;
    chk("rst_flush", ifid_flush, 1'b0);
    redirect_valid = 1'b0;
    buf_full = 1'b1; #1;
    chk("rst_stall", ifid_stall, 1'b1);
    buf_full = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("rst_cnt", cnt, 32'd0);
`endif

    // release: one IDLE cycle, then REQ
    reset = 1'b0; #1;
    chk("idle_req", imem_req, 1'b0);
    step();
    // sequential fetches 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("req%0d", k),  imem_req,  1'b1);
      chk($sformatf("addr%0d", k), imem_addr, 64'(4 * k));
      if (k == 0) begin
        step(); // no gnt: address must hold
        chk("nognt_addr", imem_addr, 64'h0);
        chk("nognt_req",  imem_req,  1'b1);
      end
      imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
      chk($sformatf("wait_req%0d", k), imem_req, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = 32'h13 + 32'(k); #1;
      chk($sformatf("valid%0d", k), if_valid, 1'b1);
      chk($sformatf("pc%0d", k),    if_pc,    64'(4 * k));
      chk($sformatf("pc4_%0d", k),  if_pc4,   64'(4 * k + 4));
      chk($sformatf("inst%0d", k),  if_inst,  32'h13 + 32'(k));
      if (k == 0) chk("wrap_pc4", w_pc4, 64'h0);
      step(); imem_rvalid = 1'b0;
      if (k == 0) chk("wrap_addr", w_addr, 64'h0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_seq", cnt, 32'd4); // 1 REQ-without-gnt + 3 WAIT
`endif

    // decode stall: HOLD keeps outputs stable
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; id_stall = 1'b1; #1;
    chk("stall_ifid",  ifid_stall, 1'b1);
    chk("stall_valid", if_valid,   1'b0);
    step(); imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_valid%0d", i), if_valid, 1'b1);
      chk($sformatf("hold_pc%0d", i),    if_pc,    64'hC);
      chk($sformatf("hold_inst%0d", i),  if_inst,  32'hAAAA_0001);
      step();
    end
    id_stall = 1'b0; #1;
    chk("rel_valid", if_valid, 1'b1);
    step();
    chk("rel_addr", imem_addr, 64'h10);

    // redirect in WAIT -> DRAIN, stale response dropped
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h1000; #1;
    chk("rw_flush", ifid_flush, 1'b1);
    chk("rw_valid", if_valid,   1'b0);
    step(); redirect_valid = 1'b0; #1;
    chk("drain_flush", ifid_flush, 1'b0);
    chk("drain_req",   imem_req,   1'b0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("drain_valid", if_valid, 1'b0);
    step(); imem_rvalid = 1'b0;
    chk("rw_addr", imem_addr, 64'h1000);
    chk("rw_req",  imem_req,  1'b1);
    chk("rw_inst", if_inst,   32'hAAAA_0001);

    // buffer full at response -> HOLD
`ifdef FETCH_PERF_CNT_EN
    cnt_snap = cnt;
`endif
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002; buf_full = 1'b1; #1;
    chk("bf_stall", ifid_stall, 1'b1);
    chk("bf_valid", if_valid,   1'b0);
    step(); imem_rvalid = 1'b0;
    chk("bf_hold_valid", if_valid, 1'b1);
    chk("bf_hold_inst",  if_inst,  32'hBBBB_0002);
    step(); buf_full = 1'b0; #1;
    chk("bf_rel_stall", ifid_stall, 1'b0);
    step();
    chk("bf_addr", imem_addr, 64'h1004);
`ifdef FETCH_PERF_CNT_EN
    chk("bf_cnt", cnt - cnt_snap, 32'd3); // 1 WAIT + 2 HOLD
`endif

    // redirect in REQ with gnt -> DRAIN
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000; #1;
    chk("rg_flush", ifid_flush, 1'b1);
    step(); imem_gnt = 1'b0; redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0003; #1;
    chk("rg_valid", if_valid, 1'b0);
    step(); imem_rvalid = 1'b0;
    chk("rg_addr", imem_addr, 64'h2000);

    // redirect in HOLD -> REQ
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDDDD_0004; id_stall = 1'b1;
    step(); imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h3000; #1;
    chk("rh_valid", if_valid,   1'b0);
    chk("rh_flush", ifid_flush, 1'b1);
    step(); redirect_valid = 1'b0; id_stall = 1'b0;
    chk("rh_addr", imem_addr, 64'h3000);
    chk("rh_req",  imem_req,  1'b1);

    // rvalid in REQ is ignored
    imem_rvalid = 1'b1; #1;
    chk("ign_valid", if_valid, 1'b0);
    step(); imem_rvalid = 1'b0;
    chk("ign_addr", imem_addr, 64'h3000);

    // reset mid-fetch abandons the request
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    reset = 1'b1; #1;
    chk("mr_req",  imem_req,  1'b0);
    chk("mr_addr", imem_addr, 64'h0);
    chk("mr_inst", if_inst,   32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_cnt", cnt, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    chk("mr_req2",  imem_req,  1'b1);
    chk("mr_addr2", imem_addr, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, PC and instruction-memory address width.
REQ-002 Parameter INST_WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, ADDR_WIDTH-bit PC loaded at reset.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-008 redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-009 id_stall  input  1  decode-stage hazard stall.
REQ-010 buf_full  input  1  IF/ID instruction buffer full flag.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  ADDR_WIDTH  fetch address.
REQ-013 imem_gnt  input  1  request accepted this cycle.
REQ-014 imem_rvalid  input  1  response valid.
REQ-015 imem_rdata  input  INST_WIDTH  fetched instruction.
REQ-016 if_valid  output  1  if_pc/if_pc4/if_inst valid for IF/ID register.
REQ-017 if_pc, if_pc4  output  ADDR_WIDTH  fetched PC and PC+4.
REQ-018 if_inst  output  INST_WIDTH  fetched instruction.
REQ-019 ifid_stall  output  1  hold IF/ID register and buffer write.
REQ-020 ifid_flush  output  1  invalidate IF/ID contents.

Function
REQ-021 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one fetch outstanding.
REQ-022 IDLE: exactly one cycle after reset release, then REQ.
REQ-023 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT, else stay REQ with address stable.
REQ-024 WAIT: imem_req=0; on imem_rvalid latch imem_rdata into if_inst; if ifid_stall=0 assert if_valid that cycle, pc<=pc+4, -> REQ; if ifid_stall=1 -> HOLD.
REQ-025 HOLD: if_valid=1 with outputs stable; first cycle with ifid_stall=0: pc<=pc+4, -> REQ.
REQ-026 ifid_stall SHALL equal id_stall OR buf_full, combinationally, in every state.
REQ-027 if_pc4 SHALL equal if_pc+4 modulo 2^ADDR_WIDTH; PC increment wraps identically.
REQ-028 redirect_valid SHALL take priority over all other events: pc<=redirect_pc, ifid_flush=1 in the same cycle (combinational), if_valid forced 0 that cycle.
REQ-029 Redirect in IDLE/REQ without gnt/HOLD -> REQ; in WAIT without rvalid, or in REQ with imem_gnt=1 -> DRAIN; in WAIT with rvalid -> REQ, response discarded.
REQ-030 DRAIN: imem_req=0, if_valid=0; the pending response is discarded on imem_rvalid, then REQ; redirect in DRAIN updates pc and stays DRAIN.
REQ-031 imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-032 Reset asserted SHALL immediately force state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pc4=0, if_inst=0, ifid_flush=0; reset mid-fetch abandons the outstanding request.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN defined: output fetch_stall_cnt (32 bits) counts cycles in REQ without gnt, WAIT, or HOLD; saturates at all-ones; cleared by reset.
REQ-034 Macro undefined: port fetch_stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset release, gnt and rvalid one cycle after each req -> addresses 0x0,0x4,0x8 issued; if_valid pulses with if_pc4=0x4,0x8,0xC.
REQ-036 rvalid with id_stall=1 for 3 cycles -> HOLD, if_valid=1 and if_pc stable 3 cycles, next imem_addr=if_pc+4 after release.
REQ-037 redirect_valid with redirect_pc=0x1000 while in WAIT -> ifid_flush=1 same cycle, DRAIN, stale rdata dropped, next imem_addr=0x1000.
REQ-038 RESET_PC=0xFFFF_FFFF_FFFF_FFFC, one fetch -> if_pc4=0x0, next imem_addr=0x0.
REQ-039 buf_full=1 at rvalid -> ifid_stall=1, HOLD; with FETCH_PERF_CNT_EN, 2 stall cycles plus 1 WAIT cycle -> fetch_stall_cnt increments by 3.
